// File: rtl/bc_ctx_pkg.sv
// bc_ctx_pkg: shared states, frame layout and register-file location codes for the context sequencer
package bc_ctx_pkg;
  typedef enum logic [2:0] {IDLE, SAVE_RD, SAVE_WR, RST_RD, RST_WB, DONE} state_t;
  localparam int DEF_NUM_GPR = 32;
  localparam int NUM_WORDS = DEF_NUM_GPR + 2;
  localparam int HI_IDX = DEF_NUM_GPR;
  localparam int LO_IDX = DEF_NUM_GPR + 1;
  localparam logic [2:0] LOC_GPR = 3'b000;
  localparam logic [2:0] LOC_HILO = 3'b001;
  localparam logic [2:0] LOC_RA = 3'b010;
  localparam logic [2:0] LOC_HI = 3'b011;
  localparam logic [2:0] LOC_LO = 3'b100;
endpackage

// File: rtl/bc_ctx_sequencer.sv
// bc_ctx_sequencer: saves/restores GPRs, HI and LO to a memory frame, stalling the pipeline meanwhile
module bc_ctx_sequencer import bc_ctx_pkg::*; #(
  parameter int NUM_GPR = DEF_NUM_GPR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_save,
  input  logic        start_restore,
  input  logic [31:0] base_addr,
  input  logic        cpu_reg_write,
  input  logic [4:0]  cpu_rd,
  input  logic [2:0]  cpu_loc_write,
  input  logic [31:0] cpu_write_data,
  input  logic [31:0] cpu_write_hi,
  input  logic [31:0] cpu_write_lo,
  input  logic [31:0] rf_read1,
  input  logic [31:0] rf_hi,
  input  logic [31:0] rf_lo,
  output logic [4:0]  rf_rs,
  output logic        rf_reg_write,
  output logic [4:0]  rf_rd,
  output logic [2:0]  rf_loc_write,
  output logic [31:0] rf_write_data,
  output logic [31:0] rf_write_hi,
  output logic [31:0] rf_write_lo,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        cpu_stall,
  output logic        done
);
  localparam logic [5:0] HI = 6'(NUM_GPR);
  localparam logic [5:0] LAST = 6'(NUM_GPR + 1);
  state_t state;
  logic [5:0] idx;
  logic [31:0] base_q, data_q;
  logic own, gpr, last;
  assign own = state != IDLE;
  assign gpr = idx < HI;
  assign last = idx == LAST;
  assign busy = own;
  assign cpu_stall = own;
  assign mem_addr = base_q + {24'd0, idx, 2'b00};
  assign mem_wdata = data_q;
  // While busy the sequencer owns the register-file port; pipeline writes are dropped
  assign rf_rs = own && gpr ? idx[4:0] : 5'd0;
  assign rf_reg_write = own ? state == RST_WB : cpu_reg_write;
  assign rf_rd = own ? (gpr ? idx[4:0] : 5'd0) : cpu_rd;
  assign rf_loc_write = own ? (gpr ? LOC_GPR : idx == HI ? LOC_HI : LOC_LO) : cpu_loc_write;
  assign rf_write_data = own ? data_q : cpu_write_data;
  assign rf_write_hi = own ? 32'd0 : cpu_write_hi;
  assign rf_write_lo = own ? 32'd0 : cpu_write_lo;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      base_q <= '0;
      data_q <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          idx <= '0;
          base_q <= {base_addr[31:2], 2'b00};
          if (start_save) state <= SAVE_RD;
          else if (start_restore) begin
            state <= RST_RD;
            mem_req <= 1'b1;
            mem_we <= 1'b0;
          end
        end
        SAVE_RD: begin
          data_q <= gpr ? rf_read1 : idx == HI ? rf_hi : rf_lo;
          mem_req <= 1'b1;
          mem_we <= 1'b1;
          state <= SAVE_WR;
        end
        SAVE_WR: if (mem_ready) begin
          mem_req <= 1'b0;
          mem_we <= 1'b0;
          idx <= last ? idx : idx + 6'd1;
          done <= last;
          state <= last ? DONE : SAVE_RD;
        end
        RST_RD: if (mem_ready) begin
          data_q <= mem_rdata;
          mem_req <= 1'b0;
          state <= RST_WB;
        end
        RST_WB: begin
          idx <= last ? idx : idx + 6'd1;
          mem_req <= !last;
          done <= last;
          state <= last ? DONE : RST_RD;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bc_ctx_sequencer.sv
// tb_bc_ctx_sequencer: scoreboard bench with register-file and wait-state memory models
module tb_bc_ctx_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start_save = 1'b0, start_restore = 1'b0, cpu_reg_write = 1'b0;
  logic [31:0] base_addr = '0;
  logic [4:0] cpu_rd = '0;
  logic [2:0] cpu_loc_write = '0;
  logic [31:0] cpu_write_data = '0, cpu_write_hi = '0, cpu_write_lo = '0;
  logic [31:0] rf_read1, rf_hi, rf_lo, rf_write_data, rf_write_hi, rf_write_lo;
  logic [4:0] rf_rs, rf_rd;
  logic [2:0] rf_loc_write;
  logic rf_reg_write, mem_req, mem_we, mem_ready, busy, cpu_stall, done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  bc_ctx_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start_save(start_save), .start_restore(start_restore),
    .base_addr(base_addr), .cpu_reg_write(cpu_reg_write), .cpu_rd(cpu_rd),
    .cpu_loc_write(cpu_loc_write), .cpu_write_data(cpu_write_data),
    .cpu_write_hi(cpu_write_hi), .cpu_write_lo(cpu_write_lo),
    .rf_read1(rf_read1), .rf_hi(rf_hi), .rf_lo(rf_lo), .rf_rs(rf_rs),
    .rf_reg_write(rf_reg_write), .rf_rd(rf_rd), .rf_loc_write(rf_loc_write),
    .rf_write_data(rf_write_data), .rf_write_hi(rf_write_hi), .rf_write_lo(rf_write_lo),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .cpu_stall(cpu_stall),
    .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] regs [32];
  logic [31:0] hi_r, lo_r;
  logic [31:0] mem [16384];
  int cnt = 0, wait_n = 0, cyc = 0;
  assign rf_read1 = regs[rf_rs];
  assign rf_hi = hi_r;
  assign rf_lo = lo_r;
  assign mem_rdata = mem[mem_addr[15:2]];
  assign mem_ready = mem_req && cnt == wait_n;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    cnt <= (mem_req && !mem_ready) ? cnt + 1 : 0;
  end

  always @(posedge clk) begin
    if (mem_req && mem_ready && mem_we) mem[mem_addr[15:2]] = mem_wdata;
    if (rf_reg_write)
      case (rf_loc_write)
        3'b000: regs[rf_rd] = rf_write_data;
        3'b001: begin hi_r = rf_write_hi; lo_r = rf_write_lo; end
        3'b011: hi_r = rf_write_data;
        3'b100: lo_r = rf_write_data;
        default: ;
      endcase
  end

  typedef struct {logic [31:0] addr; logic we; logic [31:0] data;} txn_t;
  txn_t exp_q[$];
  int done_q[$];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic we, input logic [31:0] d);
    txn_t t;
    t.addr = a; t.we = we; t.data = d;
    exp_q.push_back(t);
  endtask

  logic pend = 1'b0, p_we = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0;
  always @(negedge clk) begin
    if (!rst_n) pend = 1'b0;
    else begin
      if (mem_req && pend) begin
        chk("addr_stable", mem_addr, p_addr);
        chk("we_stable", 32'(mem_we), 32'(p_we));
        if (mem_we) chk("wdata_stable", mem_wdata, p_wdata);
      end
      if (mem_req && mem_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL mem_txn: unexpected access at 0x%08h", mem_addr);
        end else begin
          txn_t t;
          t = exp_q.pop_front();
          chk("mem_addr", mem_addr, t.addr);
          chk("mem_we", 32'(mem_we), 32'(t.we));
          if (t.we) chk("mem_wdata", mem_wdata, t.data);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL done: unexpected pulse at cycle %0d, required none", cyc);
        end else chk("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
      end
      pend = mem_req && !mem_ready;
      p_addr = mem_addr;
      p_we = mem_we;
      p_wdata = mem_wdata;
    end
  end

  task automatic wait_idle(input int lim, input string nm);
    int n = 0;
    while (busy && n < lim) begin @(negedge clk); n++; end
    chk({nm, "_idle"}, 32'(busy), 32'd0);
    chk({nm, "_txn_left"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_done_left"}, 32'(done_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h100 + 32'(i);
    hi_r = 32'hAAAA0000;
    lo_r = 32'h5555FFFF;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_stall", 32'(cpu_stall), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_rf_rs", 32'(rf_rs), 0);
    rst_n = 1'b1;
    @(negedge clk);
    // zero-wait save; simultaneous restore request must be dropped
    base_addr = 32'h1000;
    for (int i = 0; i < 34; i++)
      push(32'h1000 + 32'(4 * i), 1'b1, i < 32 ? regs[i] : i == 32 ? hi_r : lo_r);
    done_q.push_back(cyc + 69);
    start_save = 1'b1;
    start_restore = 1'b1;
    @(negedge clk);
    start_save = 1'b0;
    start_restore = 1'b0;
    chk("save_busy", 32'(busy), 1);
    repeat (3) @(negedge clk);
    cpu_reg_write = 1'b1; cpu_rd = 5'd5; cpu_loc_write = 3'b000; cpu_write_data = 32'hDEAD;
    #1;
    chk("busy_stall", 32'(cpu_stall), 1);
    chk("busy_rf_we", 32'(rf_reg_write), 0);
    @(negedge clk);
    cpu_reg_write = 1'b0;
    repeat (4) @(negedge clk);
    start_restore = 1'b1;
    @(negedge clk);
    start_restore = 1'b0;
    wait_idle(200, "save");
    chk("save_reg5", regs[5], 32'h105);
    chk("save_mem0", mem[32'h1000 >> 2], 32'h100);
    chk("save_mem31", mem[32'h107C >> 2], 32'h11F);
    chk("save_mem_hi", mem[32'h1080 >> 2], 32'hAAAA0000);
    chk("save_mem_lo", mem[32'h1084 >> 2], 32'h5555FFFF);
    // pipeline write passes through while idle
    cpu_reg_write = 1'b1; cpu_rd = 5'd5; cpu_loc_write = 3'b000; cpu_write_data = 32'hDEAD;
    #1;
    chk("idle_rf_we", 32'(rf_reg_write), 1);
    chk("idle_rf_rd", 32'(rf_rd), 5);
    chk("idle_stall", 32'(cpu_stall), 0);
    @(negedge clk);
    chk("idle_reg5", regs[5], 32'hDEAD);
    cpu_loc_write = 3'b001; cpu_write_hi = 32'h12345678; cpu_write_lo = 32'h9ABCDEF0;
    @(negedge clk);
    cpu_reg_write = 1'b0;
    chk("idle_hi", hi_r, 32'h12345678);
    chk("idle_lo", lo_r, 32'h9ABCDEF0);
    // restore with mem_ready on the third cycle of each request
    for (int i = 0; i < 34; i++) begin
      mem[(32'h2000 >> 2) + i] = 32'hC0DE0000 + 32'(i);
      push(32'h2000 + 32'(4 * i), 1'b0, 32'h0);
    end
    wait_n = 2;
    base_addr = 32'h2000;
    done_q.push_back(cyc + 69 + 68);
    start_restore = 1'b1;
    @(negedge clk);
    start_restore = 1'b0;
    wait_idle(400, "restore");
    for (int i = 0; i < 32; i++) chk($sformatf("restore_reg%0d", i), regs[i], 32'hC0DE0000 + 32'(i));
    chk("restore_hi", hi_r, 32'hC0DE0020);
    chk("restore_lo", lo_r, 32'hC0DE0021);
    // abort a restore with reset while idx 12 is outstanding
    for (int i = 0; i < 32; i++) regs[i] = '0;
    for (int i = 0; i < 34; i++) mem[(32'h3000 >> 2) + i] = 32'hBEEF0000 + 32'(i);
    for (int i = 0; i < 12; i++) push(32'h3000 + 32'(4 * i), 1'b0, 32'h0);
    base_addr = 32'h3000;
    start_restore = 1'b1;
    @(negedge clk);
    start_restore = 1'b0;
    n = 0;
    while (!(rf_reg_write && rf_rd == 5'd11) && n < 200) begin @(negedge clk); n++; end
    chk("abort_reach_idx11", 32'(rf_rd), 11);
    @(negedge clk);
    chk("abort_addr_idx12", mem_addr, 32'h3030);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_mem_req", 32'(mem_req), 0);
    chk("abort_done", 32'(done), 0);
    @(negedge clk);
    chk("abort_txn_left", 32'(exp_q.size()), 0);
    for (int i = 0; i < 32; i++)
      chk($sformatf("abort_reg%0d", i), regs[i], i < 12 ? 32'hBEEF0000 + 32'(i) : 32'h0);
    for (int i = 0; i < 32; i++) regs[i] = 32'h5A000000 + 32'(i);
    hi_r = 32'h11111111;
    lo_r = 32'h22222222;
    // save wrapping past 2^32; start asserted on the first edge out of reset
    wait_n = 0;
    base_addr = 32'hFFFFFFFB;
    for (int i = 0; i < 34; i++)
      push(32'hFFFFFFF8 + 32'(4 * i), 1'b1, i < 32 ? regs[i] : i == 32 ? hi_r : lo_r);
    @(negedge clk);
    rst_n = 1'b1;
    start_save = 1'b1;
    done_q.push_back(cyc + 69);
    @(negedge clk);
    start_save = 1'b0;
    wait_idle(200, "wrap");
    chk("wrap_mem_fff8", mem[14'h3FFE], 32'h5A000000);
    chk("wrap_mem_0000", mem[0], 32'h5A000002);
    chk("wrap_mem_lo", mem[32'h7C >> 2], 32'h22222222);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
